// File: rtl/bf_stdout_uart.sv
// bf_stdout_uart: byte FIFO fed by the brainfuck CPU's stdout strobe,
// drained by an 8N1 serial transmitter with registered line output.
module bf_stdout_uart #(
  parameter int unsigned UART_TX_BAUD = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] stdout,
  input  logic       stdout_en,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       uart_tx_pin
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_RELOAD = 16'(UART_TX_BAUD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [15:0]   baud_cnt;

  logic          wr;
  logic          pop;

  // full comes from the registered count, so a write coinciding with a pop
  // while full is still dropped.
  assign full = (count == DEPTH_CNT);
  assign wr   = stdout_en && !full;
  assign busy = (state != IDLE) || (count != '0);

  // Pop request: on leaving IDLE, or on the last cycle of a stop bit.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (count != '0);
      STOP:    pop = (baud_cnt == '0) && (count != '0);
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= stdout;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (stdout_en && full) overflow <= 1'b1;
    end
  end

  // Transmit FSM: start, 8 data bits LSB first, stop; back-to-back frames
  // reload straight from the last stop cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      uart_tx_pin <= 1'b1;
      shift       <= '0;
      bit_idx     <= '0;
      baud_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx_pin <= 1'b1;
          if (pop) begin
            shift       <= mem[rptr];
            uart_tx_pin <= 1'b0;
            baud_cnt    <= BAUD_RELOAD;
            state       <= START;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            bit_idx     <= '0;
            uart_tx_pin <= shift[0];
            baud_cnt    <= BAUD_RELOAD;
            state       <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
              uart_tx_pin <= 1'b1;
              state       <= STOP;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              uart_tx_pin <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (baud_cnt == '0) begin
            if (pop) begin
              shift       <= mem[rptr];
              uart_tx_pin <= 1'b0;
              baud_cnt    <= BAUD_RELOAD;
              state       <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state       <= IDLE;
          uart_tx_pin <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_stdout_uart.sv
// Testbench for bf_stdout_uart: three configurations checked every cycle
// against a queue/timer reference model, plus a vector table and directed
// sequences decoded by a line receiver.
module tb_bf_stdout_uart;

  localparam int BB [3] = '{4, 1, 8};
  localparam int DD [3] = '{16, 16, 4};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en     [3];
  logic [7:0] din    [3];
  logic       full_o [3];
  logic       busy_o [3];
  logic       ov_o   [3];
  logic       pin_o  [3];

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  bf_stdout_uart #(.UART_TX_BAUD(4), .FIFO_DEPTH(16)) u_b4 (
    .clk(clk), .rst_n(rst_n), .stdout(din[0]), .stdout_en(en[0]),
    .full(full_o[0]), .busy(busy_o[0]), .overflow(ov_o[0]), .uart_tx_pin(pin_o[0]));
  bf_stdout_uart #(.UART_TX_BAUD(1), .FIFO_DEPTH(16)) u_b1 (
    .clk(clk), .rst_n(rst_n), .stdout(din[1]), .stdout_en(en[1]),
    .full(full_o[1]), .busy(busy_o[1]), .overflow(ov_o[1]), .uart_tx_pin(pin_o[1]));
  bf_stdout_uart #(.UART_TX_BAUD(8), .FIFO_DEPTH(4)) u_b8 (
    .clk(clk), .rst_n(rst_n), .stdout(din[2]), .stdout_en(en[2]),
    .full(full_o[2]), .busy(busy_o[2]), .overflow(ov_o[2]), .uart_tx_pin(pin_o[2]));

  // Reference model: a circular byte queue plus a frame timer counting the
  // cycles left in the frame on the line (0 = line idle).
  logic [7:0] mq [3][16];
  int         mh [3];
  int         ms [3];
  int         mt [3];
  bit         mov [3];
  logic [7:0] mcur [3];

  logic [7:0] acc[$];
  logic [7:0] rxq[$];
  bit         logq[$];
  bit         log_on = 1'b0;
  int         log_inst = 0;

  function automatic void mreset();
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0; ms[i] = 0; mt[i] = 0; mov[i] = 1'b0; mcur[i] = '0;
    end
  endfunction

  function automatic void mstep(int i, bit e, logic [7:0] d);
    bit fp = (ms[i] == DD[i]);
    if (mt[i] <= 1 && ms[i] > 0) begin
      mcur[i] = mq[i][mh[i]];
      mh[i] = (mh[i] + 1) % DD[i];
      ms[i]--;
      mt[i] = 10 * BB[i];
    end else if (mt[i] > 0) begin
      mt[i]--;
    end
    if (e) begin
      if (fp) mov[i] = 1'b1;
      else begin
        mq[i][(mh[i] + ms[i]) % DD[i]] = d;
        ms[i]++;
        if (log_on && i == log_inst) acc.push_back(d);
      end
    end
  endfunction

  function automatic int mpin(int i);
    int k;
    if (mt[i] == 0) return 1;
    k = (10 * BB[i] - mt[i]) / BB[i];
    if (k == 0) return 0;
    if (k == 9) return 1;
    return int'(mcur[i][k-1]);
  endfunction

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) mreset();
    else for (int i = 0; i < 3; i++) mstep(i, en[i], din[i]);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_pin%0d", i),  int'(pin_o[i]),  mpin(i));
      chk($sformatf("model_busy%0d", i), int'(busy_o[i]), int'(mt[i] > 0 || ms[i] > 0));
      chk($sformatf("model_full%0d", i), int'(full_o[i]), int'(ms[i] == DD[i]));
      chk($sformatf("model_ovf%0d", i),  int'(ov_o[i]),   int'(mov[i]));
    end
    if (log_on) logq.push_back(pin_o[log_inst]);
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
  endtask

  // Line receiver over the logged pin samples: samples each bit's first cycle.
  function automatic void decode(int b);
    int i = 0;
    logic [7:0] v;
    rxq.delete();
    while (i + 10 * b <= logq.size()) begin
      if (logq[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) v[k] = logq[i + b * (k + 1)];
        rxq.push_back(v);
        i += 10 * b;
      end else begin
        i++;
      end
    end
  endfunction

  typedef struct {
    bit         en;
    logic [7:0] d;
    bit         pin;
    bit         busy;
    bit         full;
    bit         ov;
  } vec_t;

  vec_t tab [23];
  bit   exp41 [10];

  initial begin
    int attempts;
    int cyc;

    // "Hi" back-to-back at baud 1: entry v applied before edge E+v,
    // expectations hold after that edge.
    tab = '{
      '{1'b1, 8'h48, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h69, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}
    };
    exp41 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin en[i] = 1'b0; din[i] = '0; end
    mreset();
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_pin%0d", i),  int'(pin_o[i]),  1);
      chk($sformatf("reset_busy%0d", i), int'(busy_o[i]), 0);
      chk($sformatf("reset_full%0d", i), int'(full_o[i]), 0);
      chk($sformatf("reset_ovf%0d", i),  int'(ov_o[i]),   0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Vector table: back-to-back "Hi" at baud 1.
    logq.delete(); log_inst = 1; log_on = 1'b1;
    for (int v = 0; v < 23; v++) begin
      en[1] = tab[v].en; din[1] = tab[v].d;
      tick();
      chk($sformatf("hi_pin[%0d]", v),  int'(pin_o[1]),  int'(tab[v].pin));
      chk($sformatf("hi_busy[%0d]", v), int'(busy_o[1]), int'(tab[v].busy));
      chk($sformatf("hi_full[%0d]", v), int'(full_o[1]), int'(tab[v].full));
      chk($sformatf("hi_ovf[%0d]", v),  int'(ov_o[1]),   int'(tab[v].ov));
    end
    log_on = 1'b0;
    decode(1);
    chk("hi_count", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk("hi_byte0", int'(rxq[0]), 'h48);
      chk("hi_byte1", int'(rxq[1]), 'h69);
    end

    // Single byte 0x41 at baud 4.
    logq.delete(); log_inst = 0; log_on = 1'b1;
    en[0] = 1'b1; din[0] = 8'h41;
    tick();
    for (int c = 0; c < 41; c++) tick();
    log_on = 1'b0;
    chk("a_idle_before", int'(logq[0]), 1);
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("a_bit%0d_c%0d", k, c), int'(logq[1 + 4*k + c]), int'(exp41[k]));
    chk("a_busy_end", int'(busy_o[0]), 0);
    decode(4);
    chk("a_count", rxq.size(), 1);
    if (rxq.size() == 1) chk("a_byte", int'(rxq[0]), 'h41);

    // Fill and overflow: depth 4, baud 8, bytes 0..5 on consecutive edges.
    logq.delete(); log_inst = 2; log_on = 1'b1;
    for (int b = 0; b < 6; b++) begin
      en[2] = 1'b1; din[2] = 8'(b);
      tick();
      if (b == 4) begin
        chk("fill_full_at4", int'(full_o[2]), 1);
        chk("fill_ovf_at4",  int'(ov_o[2]),   0);
      end
    end
    chk("fill_ovf_at5",  int'(ov_o[2]),   1);
    chk("fill_full_at5", int'(full_o[2]), 1);
    for (int c = 0; c < 75; c++) tick();
    chk("fill_full_e80", int'(full_o[2]), 1);
    tick();
    chk("fill_full_e81", int'(full_o[2]), 0);
    for (int c = 0; c < 340; c++) tick();
    log_on = 1'b0;
    decode(8);
    chk("fill_count", rxq.size(), 5);
    for (int k = 0; k < 5 && k < rxq.size(); k++)
      chk($sformatf("fill_byte%0d", k), int'(rxq[k]), k);

    // Minimum baud: 0x55 alternates every cycle.
    logq.delete(); log_inst = 1; log_on = 1'b1;
    en[1] = 1'b1; din[1] = 8'h55;
    tick();
    for (int c = 0; c < 11; c++) tick();
    log_on = 1'b0;
    for (int k = 0; k < 10; k++)
      chk($sformatf("x55_bit%0d", k), int'(logq[1 + k]), k % 2);
    chk("x55_idle", int'(logq[11]), 1);

    // Random scoreboard at baud 1 with random strobe gaps.
    logq.delete(); acc.delete(); log_inst = 1; log_on = 1'b1;
    attempts = 0; cyc = 0;
    while (attempts < 200 && cyc < 20000) begin
      if ($urandom_range(0, 11) == 0) begin
        en[1] = 1'b1; din[1] = 8'($urandom); attempts++;
      end
      tick();
      cyc++;
    end
    chk("rand_budget", int'(attempts == 200), 1);
    for (int c = 0; c < 200; c++) tick();
    log_on = 1'b0;
    decode(1);
    chk("rand_count", rxq.size(), acc.size());
    for (int k = 0; k < rxq.size() && k < acc.size(); k++)
      chk($sformatf("rand_byte%0d", k), int'(rxq[k]), int'(acc[k]));

    // Reset mid-frame: baud 4, reset during data bit 3 with 2 bytes queued.
    en[0] = 1'b1; din[0] = 8'hA5; tick();
    en[0] = 1'b1; din[0] = 8'hC3; tick();
    en[0] = 1'b1; din[0] = 8'h3C; tick();
    for (int c = 0; c < 16; c++) tick();
    chk("rst_pre_busy", int'(busy_o[0]), 1);
    chk("rst_pre_ovf8", int'(ov_o[2]),   1);
    rst_n = 1'b0;
    #1;
    chk("rst_pin",  int'(pin_o[0]),  1);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_full", int'(full_o[0]), 0);
    chk("rst_ovf8", int'(ov_o[2]),   0);
    mreset();
    for (int c = 0; c < 3; c++) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk($sformatf("rst_quiet_pin%0d", c), int'(pin_o[0]), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
